// File: rtl/spram_ctrl_pkg.sv
// Shared definitions for the single-port RAM access controller.
// Build option SPRAM_INIT_CLEAR_EN enables the post-reset clearing sweep.
package spram_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADR_W  = 6;
    localparam int unsigned DEPTH  = 2 ** ADR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_WR   = 2'b01,
        GNT_RD   = 2'b10
    } gnt_e;

endpackage

// File: rtl/spram_access_ctrl_arb.sv
// Two-requester round-robin arbiter: req_i[0]=write, req_i[1]=read.
// The last-grant flag resets to "read" so the first tie goes to the write.
module spram_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       last_rd_o
);

    logic last_rd_q;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_rd_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_q <= 1'b1;
        end else if (gnt_o[0]) begin
            last_rd_q <= 1'b0;
        end else if (gnt_o[1]) begin
            last_rd_q <= 1'b1;
        end
    end

    assign last_rd_o = last_rd_q;

endmodule

// File: rtl/spram_access_ctrl.sv
// Arbitrating front-end for a 64x8 single-port RAM (en=1 write, en=0 read).
// Build option SPRAM_INIT_CLEAR_EN: zero-fill sweep of all addresses after reset.
module spram_access_ctrl
    import spram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = spram_ctrl_pkg::DATA_W,
    parameter int unsigned ADR_W  = spram_ctrl_pkg::ADR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADR_W-1:0]  wr_adr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADR_W-1:0]  rd_adr,
    output logic              rd_dvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADR_W-1:0]  ram_adr,
    output logic              ram_en,
    input  logic [DATA_W-1:0] ram_out
);

    state_e            state_q;
    logic [ADR_W-1:0]  init_adr;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] data_q;
    logic              rd_pend_q;
    logic              rd_dvalid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              run;
    logic              init_act;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              last_rd;

`ifdef SPRAM_INIT_CLEAR_EN
    logic [ADR_W-1:0] init_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_q + ADR_W'(1);
            if (&init_cnt_q) begin
                state_q <= ST_RUN;
            end
        end
    end

    assign init_adr = init_cnt_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= ST_RUN;
        end
    end

    assign init_adr = '0;
`endif

    // Gating with rst_n keeps every output at 0 while reset is held.
    assign run      = rst_n && (state_q == ST_RUN);
    assign init_act = rst_n && (state_q == ST_INIT);
    assign busy     = init_act;

    assign req = {rd_valid & run, wr_valid & run};

    spram_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .last_rd_o (last_rd)
    );

    // Each ready says "this stream would win now", so it never looks at the other ready.
    assign wr_ready = run && (!rd_valid || last_rd);
    assign rd_ready = run && (!wr_valid || !last_rd);

    always_comb begin
        ram_en   = 1'b0;
        ram_adr  = adr_q;
        ram_data = data_q;
        if (init_act) begin
            ram_en   = 1'b1;
            ram_adr  = init_adr;
            ram_data = '0;
        end else if (gnt == GNT_WR) begin
            ram_en   = 1'b1;
            ram_adr  = wr_adr;
            ram_data = wr_data;
        end else if (gnt == GNT_RD) begin
            ram_adr  = rd_adr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q       <= '0;
            data_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_dvalid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_pend_q   <= (gnt == GNT_RD);
            rd_dvalid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= ram_out;
            end
            if (init_act || (gnt != GNT_NONE)) begin
                adr_q  <= ram_adr;
                data_q <= ram_data;
            end
        end
    end

    assign rd_dvalid = rd_dvalid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Bench for spram_access_ctrl with a behavioural single-port RAM behind it.
// Honours SPRAM_INIT_CLEAR_EN the same way as the design.
module tb_spram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid, rd_valid;
    logic       wr_ready, rd_ready;
    logic [5:0] wr_adr, rd_adr;
    logic [7:0] wr_data;
    logic       rd_dvalid;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] ram_data;
    logic [5:0] ram_adr;
    logic       ram_en;
    logic [7:0] ram_out;

`ifdef SPRAM_INIT_CLEAR_EN
    localparam int INIT_CYCLES = 64;
`else
    localparam int INIT_CYCLES = 0;
`endif

    always #5 clk = ~clk;

    spram_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_adr    (wr_adr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_adr    (rd_adr),
        .rd_dvalid (rd_dvalid),
        .rd_data   (rd_data),
        .busy      (busy),
        .ram_data  (ram_data),
        .ram_adr   (ram_adr),
        .ram_en    (ram_en),
        .ram_out   (ram_out)
    );

    // single_port_ram stand-in
    logic [7:0] ram_mem [64];
    always @(posedge clk) begin
        if (ram_en) ram_mem[ram_adr] <= ram_data;
        else        ram_out <= ram_mem[ram_adr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {int due; logic [7:0] d;} rq_t;
    rq_t        pq[$];
    logic [7:0] ref_mem [64];
    bit         last_rd_m;
    int         init_left;
    int         hold_adr;
    int         hold_data;
    int         last_rdata;
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];

    always @(negedge clk) begin
        bit run_m, e_wrr, e_rdr, gw, gr, e_en, e_dv;
        int e_adr, e_data;
        rq_t r;
        cyc++;
        if (rd_dvalid === 1'b1) begin
            got_q.push_back(rd_data);
            got_cyc.push_back(cyc);
        end
        if (rst_n !== 1'b1) begin
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_adr", ram_adr, 0);
            chk("rst_ram_data", ram_data, 0);
            chk("rst_rd_dvalid", rd_dvalid, 0);
            chk("rst_rd_data", rd_data, 0);
            last_rd_m  = 1'b1;
            init_left  = INIT_CYCLES;
            hold_adr   = 0;
            hold_data  = 0;
            last_rdata = 0;
            pq.delete();
        end else begin
            run_m = (init_left == 0);
            e_wrr = run_m && (!rd_valid || last_rd_m);
            e_rdr = run_m && (!wr_valid || !last_rd_m);
            gw    = wr_valid && e_wrr;
            gr    = rd_valid && e_rdr;
            e_en   = 1'b0;
            e_adr  = hold_adr;
            e_data = hold_data;
            if (!run_m) begin
                e_en   = 1'b1;
                e_adr  = 64 - init_left;
                e_data = 0;
            end else if (gw) begin
                e_en   = 1'b1;
                e_adr  = wr_adr;
                e_data = wr_data;
            end else if (gr) begin
                e_adr  = rd_adr;
            end
            e_dv = (pq.size() > 0) && (pq[0].due == cyc);
            if (e_dv) begin
                last_rdata = pq[0].d;
                void'(pq.pop_front());
            end
            chk("wr_ready", wr_ready, e_wrr);
            chk("rd_ready", rd_ready, e_rdr);
            chk("busy", busy, !run_m);
            chk("ram_en", ram_en, e_en);
            chk("ram_adr", ram_adr, e_adr);
            chk("ram_data", ram_data, e_data);
            chk("rd_dvalid", rd_dvalid, e_dv);
            chk("rd_data", rd_data, last_rdata);
            if (!run_m) begin
                ref_mem[e_adr] = 8'h00;
                init_left--;
            end
            if (gw) begin
                ref_mem[wr_adr] = wr_data;
                last_rd_m = 1'b0;
            end
            if (gr) begin
                r.due = cyc + 2;
                r.d   = ref_mem[rd_adr];
                pq.push_back(r);
                last_rd_m = 1'b1;
            end
            hold_adr  = e_adr;
            hold_data = e_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got_q.size() < n && k < 20) begin
            step();
            k++;
        end
        chk("got_count", got_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         h;
        logic [7:0] init17;
        logic [3:0] tie_pat;
        logic [7:0] exp_rd [4];
        logic [5:0] rd_seq [4];

        rst_n = 1'b0;
        idle();
        wr_adr = '0; rd_adr = '0; wr_data = '0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 8'($urandom_range(1, 255));
            ref_mem[i] = ram_mem[i];
        end
        init17 = ram_mem[17];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        wait_run(n);
        chk("busy_cycles_after_reset", n, INIT_CYCLES);

        // Read adr 17: cleared by the sweep when enabled, otherwise untouched
        got_q.delete(); got_cyc.delete();
        rd_valid = 1'b1; rd_adr = 6'd17;
        step();
        idle();
        wait_got(1);
`ifdef SPRAM_INIT_CLEAR_EN
        if (got_q.size() > 0) chk("adr17_cleared", got_q[0], 8'h00);
`else
        if (got_q.size() > 0) chk("adr17_untouched", got_q[0], init17);
`endif

        // Reset pulse right after a read handshake
        got_q.delete(); got_cyc.delete();
        rd_valid = 1'b1; rd_adr = 6'd5;
        step();
        rd_valid = 1'b1; wr_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_pulse_wr_ready", wr_ready, 0);
        chk("rst_pulse_rd_ready", rd_ready, 0);
        chk("rst_pulse_ram_en", ram_en, 0);
        chk("rst_pulse_busy", busy, 0);
        idle();
        step();
        rst_n = 1'b1;
        #1;
        wait_run(n);
        chk("busy_cycles_after_pulse", n, INIT_CYCLES);
        repeat (4) step();
        chk("no_dvalid_after_reset", got_q.size(), 0);

        // Writes 01..04 to adr 0..3
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_adr = 6'(i); wr_data = 8'(i + 1);
            #1;
            chk("wr_seq_ready", wr_ready, 1);
            chk("wr_seq_ram_en", ram_en, 1);
            chk("wr_seq_ram_adr", ram_adr, i);
            step();
        end
        idle();

        // Back-to-back reads of adr 2,1,3,0
        rd_seq[0] = 6'd2; rd_seq[1] = 6'd1; rd_seq[2] = 6'd3; rd_seq[3] = 6'd0;
        exp_rd[0] = 8'h03; exp_rd[1] = 8'h02; exp_rd[2] = 8'h04; exp_rd[3] = 8'h01;
        got_q.delete(); got_cyc.delete();
        h = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1; rd_adr = rd_seq[i];
            step();
        end
        idle();
        wait_got(4);
        if (got_q.size() == 4) begin
            chk("rd_latency", got_cyc[0] - h, 2);
            for (int i = 0; i < 4; i++) begin
                chk("rd_seq_data", got_q[i], exp_rd[i]);
                chk("rd_seq_consecutive", got_cyc[i] - got_cyc[0], i);
            end
        end

        // Both valid for 4 cycles: W,R,W,R
        tie_pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_adr = 6'd10; wr_data = 8'(8'h40 + i);
            rd_valid = 1'b1; rd_adr = 6'd20;
            #1;
            chk("tie_ram_en", ram_en, tie_pat[i]);
            chk("tie_wr_ready", wr_ready, tie_pat[i]);
            chk("tie_rd_ready", rd_ready, !tie_pat[i]);
            step();
        end
        idle();
        repeat (3) step();

        // Write A5 to adr 63, read it back on the next cycle
        got_q.delete(); got_cyc.delete();
        wr_valid = 1'b1; wr_adr = 6'd63; wr_data = 8'hA5;
        step();
        idle();
        rd_valid = 1'b1; rd_adr = 6'd63;
        step();
        idle();
        wait_got(1);
        if (got_q.size() > 0) chk("adr63_readback", got_q[0], 8'hA5);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            rd_valid = 1'($urandom_range(0, 1));
            wr_adr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            rd_adr   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            wr_data  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end
        idle();
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
